// File: rtl/hilo_sched.sv
// HI/LO register pair and sequencer for the shared iterative mul/div engine.
// States: IDLE accept op | ISSUE engine start pulse | WAIT await done or timeout | WB retire, PC advances.
module hilo_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div0,
  output logic        timeout,
  output logic        eng_start,
  output logic        eng_is_div,
  output logic        eng_signed,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  input  logic        eng_done,
  input  logic [31:0] eng_hi,
  input  logic [31:0] eng_lo
);

  localparam logic [2:0] OP_DIV   = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div_op;
  logic             eop;
  logic             dz;

  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign eop = op_valid && (is_div_op || (op == OP_MULT) || (op == OP_MULTU));
  assign dz  = is_div_op && (rt_data == 32'd0);

  assign stall = ((state == IDLE) && eop && !dz) || (state == ISSUE) || (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_out     <= '0;
      lo_out     <= '0;
      div0       <= 1'b0;
      timeout    <= 1'b0;
      eng_start  <= 1'b0;
      eng_is_div <= 1'b0;
      eng_signed <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
    end else begin
      eng_start <= 1'b0;
      div0      <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (eop && !dz) begin
            eng_a      <= rs_data;
            eng_b      <= rt_data;
            eng_is_div <= is_div_op;
            eng_signed <= (op == OP_DIV) || (op == OP_MULT);
            eng_start  <= 1'b1;
            state      <= ISSUE;
          end else if (eop) begin
            div0 <= 1'b1;
          end else if (op_valid && (op == OP_MTHI)) begin
            hi_out <= rs_data;
          end else if (op_valid && (op == OP_MTLO)) begin
            lo_out <= rs_data;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done in the final allowed cycle still wins over the timeout.
          if (eng_done) begin
            hi_out <= eng_hi;
            lo_out <= eng_lo;
            state  <= WB;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sched.sv
// Directed self-checking bench for hilo_sched: reset, MTHI/MTLO, DIVU, MULT, div-by-zero, timeout, reset mid-WAIT.
module tb_hilo_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        stall, div0, timeout, eng_start, eng_is_div, eng_signed;
  logic [31:0] hi_out, lo_out, eng_a, eng_b;
  logic        eng_done;
  logic [31:0] eng_hi, eng_lo;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  int n_stall, n_start;
  bit retired;

  hilo_sched #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
    .hi_out(hi_out), .lo_out(lo_out), .div0(div0), .timeout(timeout),
    .eng_start(eng_start), .eng_is_div(eng_is_div), .eng_signed(eng_signed),
    .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done),
    .eng_hi(eng_hi), .eng_lo(eng_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one engine op and plays the engine: done on WAIT cycle done_at (0 = never).
  // Returns at the first non-stalled cycle (WB), sampled mid-cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int done_at, input logic [31:0] rhi, input logic [31:0] rlo,
                        output int ns, output int nst, output bit ret);
    ns = 0; nst = 0; ret = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
      eng_hi = rhi; eng_lo = rlo;
      eng_done = (done_at != 0) && (c == done_at + 1);
      #1;
      if (stall) ns++;
      if (eng_start) nst++;
      if (!stall) begin
        ret = 1'b1;
        break;
      end
    end
    eng_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 3'b000; rs_data = '0; rt_data = '0;
    eng_done = 1'b0; eng_hi = '0; eng_lo = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_eng", {26'd0, eng_start, eng_is_div, eng_signed, div0, timeout, 1'b0}, 32'd0);
    chk("rst_eng_a", eng_a, 32'd0);
    chk("rst_eng_b", eng_b, 32'd0);
    rst = 1'b0;

    // MTHI then MTLO, plus a no-op code that must not disturb HI/LO
    @(negedge clk); op_valid = 1'b1; op = 3'b101; rs_data = 32'h12345678; #1;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    chk("mthi_before", hi_out, 32'd0);
    @(negedge clk); op = 3'b110; rs_data = 32'h9ABCDEF0; #1;
    chk("mthi_hi", hi_out, 32'h12345678);
    chk("mtlo_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); op = 3'b111; rs_data = 32'hDEADBEEF; #1;
    chk("mtlo_lo", lo_out, 32'h9ABCDEF0);
    @(negedge clk); op_valid = 1'b0; #1;
    chk("noop_hi", hi_out, 32'h12345678);
    chk("noop_lo", lo_out, 32'h9ABCDEF0);

    // DIVU 100/7, done on the 33rd WAIT cycle
    run_op(3'b010, 32'd100, 32'd7, 33, 32'd2, 32'd14, n_stall, n_start, retired);
    chk("divu_retired", {31'd0, retired}, 32'd1);
    chk("divu_stall_cycles", n_stall, 32'd35);
    chk("divu_start_pulses", n_start, 32'd1);
    chk("divu_hi", hi_out, 32'd2);
    chk("divu_lo", lo_out, 32'd14);
    chk("divu_flags", {29'd0, eng_is_div, eng_signed, timeout}, 32'b100);
    chk("divu_a", eng_a, 32'd100);
    chk("divu_b", eng_b, 32'd7);
    @(negedge clk); op_valid = 1'b0;

    // MULT -1 * 5, done on the first WAIT cycle
    run_op(3'b011, 32'hFFFFFFFF, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFFB, n_stall, n_start, retired);
    chk("mult_retired", {31'd0, retired}, 32'd1);
    chk("mult_stall_cycles", n_stall, 32'd3);
    chk("mult_start_pulses", n_start, 32'd1);
    chk("mult_hi", hi_out, 32'hFFFFFFFF);
    chk("mult_lo", lo_out, 32'hFFFFFFFB);
    chk("mult_flags", {30'd0, eng_is_div, eng_signed}, 32'b01);
    @(negedge clk); op_valid = 1'b0;

    // DIV by zero: no stall, no start, single div0 pulse
    @(negedge clk); op_valid = 1'b1; op = 3'b001; rs_data = 32'd10; rt_data = 32'd0; #1;
    chk("dz_stall", {31'd0, stall}, 32'd0);
    chk("dz_start", {31'd0, eng_start}, 32'd0);
    chk("dz_div0_early", {31'd0, div0}, 32'd0);
    @(negedge clk); op_valid = 1'b0; #1;
    chk("dz_div0", {31'd0, div0}, 32'd1);
    chk("dz_start2", {31'd0, eng_start}, 32'd0);
    chk("dz_hi", hi_out, 32'hFFFFFFFF);
    chk("dz_lo", lo_out, 32'hFFFFFFFB);
    @(negedge clk); #1;
    chk("dz_div0_end", {31'd0, div0}, 32'd0);

    // MULTU with the engine never answering
    run_op(3'b100, 32'd3, 32'd4, 0, 32'hAAAAAAAA, 32'h55555555, n_stall, n_start, retired);
    chk("to_retired", {31'd0, retired}, 32'd1);
    chk("to_stall_cycles", n_stall, 32'd66);
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_hi", hi_out, 32'hFFFFFFFF);
    chk("to_lo", lo_out, 32'hFFFFFFFB);
    @(negedge clk); op_valid = 1'b0; #1;
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    chk("to_idle_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); op_valid = 1'b1; op = 3'b101; rs_data = 32'h0BADF00D; #1;
    chk("to_idle_mthi_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); op_valid = 1'b0; #1;
    chk("to_idle_mthi", hi_out, 32'h0BADF00D);

    // Reset in the middle of WAIT, then a stray done
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      op_valid = 1'b1; op = 3'b010; rs_data = 32'd5; rt_data = 32'd1;
      #1;
      if (c == 3) chk("rw_in_wait", {31'd0, stall}, 32'd1);
    end
    op_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_hi", hi_out, 32'd0);
    chk("rw_lo", lo_out, 32'd0);
    chk("rw_eng_a", eng_a, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); eng_done = 1'b1; eng_hi = 32'h11111111; eng_lo = 32'h22222222; #1;
    chk("rw_done_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); eng_done = 1'b0; #1;
    chk("rw_late_hi", hi_out, 32'd0);
    chk("rw_late_lo", lo_out, 32'd0);
    chk("rw_late_stall", {31'd0, stall}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hilo_sched.md
Name: hilo_sched

Overview:
- Controller for the HI/LO register pair and a shared iterative multiply/divide engine in the MIPS core.
- Decodes the mul/div/move-to-HI/LO operation presented by the decoder.
- Latches the operands, issues a single start pulse to the engine, and stalls PC advance until the engine returns.
- Writes the result into HI/LO, and provides HI/LO read data for MFHI/MFLO.

Parameters:
- TIMEOUT, 64, maximum cycles spent in WAIT before the operation is abandoned.
- CNT_W, 7, width of the WAIT-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- op_valid  in  1  decoder presents a HI/LO-class instruction this cycle.
- op  in  3  001 DIV, 010 DIVU, 011 MULT, 100 MULTU, 101 MTHI, 110 MTLO; all other codes are no-ops.
- rs_data  in  32  GPR[rs].
- rt_data  in  32  GPR[rt].
- stall  out  1  hold PC and suppress regfile write this cycle.
- hi_out  out  32  current HI.
- lo_out  out  32  current LO.
- div0  out  1  one-cycle pulse: DIV/DIVU with rt_data==0 was retired.
- timeout  out  1  one-cycle pulse: the engine failed to complete within TIMEOUT cycles.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_is_div  out  1  1 = divide, 0 = multiply.
- eng_signed  out  1  1 = signed operation (DIV, MULT).
- eng_a  out  32  latched rs operand.
- eng_b  out  32  latched rt operand.
- eng_done  in  1  engine result valid; sampled only in WAIT.
- eng_hi  in  32  engine HI result (remainder or product[63:32]).
- eng_lo  in  32  engine LO result (quotient or product[31:0]).

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; HI = LO = 0; counter = 0.
  - Outputs: eng_start = eng_is_div = eng_signed = 0; eng_a = eng_b = 0; div0 = timeout = 0.
  - Reset mid-operation aborts the operation; a later eng_done is ignored.
- The engine-class operation ("eop") is op in {001, 010, 011, 100} with op_valid=1.
- The division-by-zero condition ("dz") is op in {001, 010} with rt_data==0.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - eop & !dz: latch rs_data/rt_data into eng_a/eng_b, set eng_is_div and eng_signed, go to ISSUE.
  - eop & dz: stay in IDLE; HI/LO unchanged; div0=1 on the next cycle.
  - op=101: HI <= rs_data at this edge.
  - op=110: LO <= rs_data at this edge.
  - Any other op: no action.
- ISSUE: eng_start=1 for exactly this cycle; counter <= 0; go to WAIT. eng_done is ignored in ISSUE.
- WAIT:
  - eng_done=1: HI <= eng_hi, LO <= eng_lo; go to WB.
  - Otherwise counter++.
  - counter==TIMEOUT-1 with no done: go to WB with no HI/LO write; timeout=1 on the next cycle.
- WB:
  - stall=0 so the PC advances past the instruction.
  - Inputs are ignored, because the still-presented op is the instruction being retired.
  - Go to IDLE.
- stall (combinational) = (IDLE & eop & !dz) | ISSUE | WAIT.
- Latency: minimum 4 cycles from issue to retire with eng_done asserted in the first WAIT cycle. The sequence is IDLE(stall) -> ISSUE(stall) -> WAIT(stall) -> WB.
- hi_out/lo_out are registered values.
  - An MFHI/MFLO immediately after retire sees the new values.
  - MTHI/MTLO are visible the cycle after they execute.
- eng_a/eng_b/eng_is_div/eng_signed hold their latched values from ISSUE through WB; the engine may sample them at any point in that window.
- No overlap: only one operation is in flight. A new op is accepted only in IDLE.

Test Plan:
- Reset during WAIT: assert rst mid-WAIT -> state IDLE, HI=LO=0, stall=0 immediately; a later eng_done leaves HI/LO at 0.
- DIVU rs=100, rt=7, engine done after 33 cycles returning hi=2, lo=14 -> eng_start pulses once; stall high 35 cycles; then HI=2, LO=14 and stall low in WB.
- MULT rs=0xFFFFFFFF (-1), rt=5, done on the first WAIT cycle with hi=0xFFFFFFFF, lo=0xFFFFFFFB -> eng_signed=1, eng_is_div=0; exactly 3 stall cycles; HI/LO updated.
- DIV rs=10, rt=0 -> no stall, no eng_start, HI/LO unchanged, div0 pulses one cycle.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 -> hi_out/lo_out show the values one cycle after each; no stall.
- TIMEOUT=64, eng_done never asserted -> stall high for 1+1+64 cycles; timeout pulse; HI/LO unchanged; back to IDLE.
